conv_1d_result_streamer: RTL

- Consumer-side companion to the fully parallel 1D convolution core.
- Captures one complete result frame (all RESULT_D channels x RESULT_W positions, plus its 8-bit opaque tag) in a single transfer.
- Replays the frame as a valid/ready stream of RESULT_W beats; each beat carries all RESULT_D channels of one output position.
- Sits between the conv core's wide result bus and downstream narrow datapaths such as pooling, writeback DMA or the next layer's loader.

---
 rtl/conv_1d_result_streamer.sv | 85 ++++++++
 1 files changed

// File: rtl/conv_1d_result_streamer.sv
// rtl/conv_1d_result_streamer.sv - captures one wide conv result frame and replays it one position per beat
module conv_1d_result_streamer #(
  parameter int DATA_WIDTH = 8,
  parameter int IMG_W      = 32,
  parameter int FILTER_L   = 3,
  parameter int STRIDE_W   = 1,
  parameter int RESULT_D   = 8,
  localparam int RESULT_W  = (IMG_W - FILTER_L) / STRIDE_W + 1,
  localparam int RESULT_W_ADDR_WIDTH = (RESULT_W > 1) ? $clog2(RESULT_W) : 1
) (
  input  logic                                     clk,
  input  logic                                     reset,
  input  logic                                     in_valid,
  output logic                                     in_ready,
  input  logic [DATA_WIDTH*RESULT_D*RESULT_W-1:0]  lines_in,
  input  logic [7:0]                               opaque_in,
  output logic                                     out_valid,
  input  logic                                     out_ready,
  output logic [DATA_WIDTH*RESULT_D-1:0]           out_data,
  output logic [RESULT_W_ADDR_WIDTH-1:0]           out_index,
  output logic                                     out_last,
  output logic [7:0]                               out_opaque
);

  localparam int FRAME_BITS = DATA_WIDTH * RESULT_D * RESULT_W;
  localparam logic [RESULT_W_ADDR_WIDTH-1:0] LAST_IDX = RESULT_W_ADDR_WIDTH'(RESULT_W - 1);

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } state_t;

  state_t                         state;
  logic [FRAME_BITS-1:0]          frame;
  logic [RESULT_W_ADDR_WIDTH-1:0] index;
  logic [RESULT_W_ADDR_WIDTH-1:0] next_index;
  logic                           beat;
  logic                           accept;

  assign beat       = out_valid && out_ready;
  assign in_ready   = !reset && (state == IDLE || (beat && out_last));
  assign accept     = in_valid && in_ready;
  assign next_index = index + 1'b1;
  assign out_index  = index;

  // A handshake on the last beat may coincide with the next accept, so the
  // accept branch takes priority and streaming continues without a bubble.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      frame      <= '0;
      index      <= '0;
      out_valid  <= 1'b0;
      out_last   <= 1'b0;
      out_opaque <= 8'h00;
    end else if (accept) begin
      state      <= STREAM;
      frame      <= lines_in;
      out_opaque <= opaque_in;
      index      <= '0;
      out_valid  <= 1'b1;
      out_last   <= (RESULT_W == 1);
    end else if (beat) begin
      if (out_last) begin
        state     <= IDLE;
        index     <= '0;
        out_valid <= 1'b0;
        out_last  <= 1'b0;
      end else begin
        index    <= next_index;
        out_last <= (next_index == LAST_IDX);
      end
    end
  end

  // Transpose: gather channel d of position index from the channel-major buffer.
  always_comb begin
    out_data = '0;
    for (int d = 0; d < RESULT_D; d++) begin
      out_data[d*DATA_WIDTH +: DATA_WIDTH] =
        frame[(d*RESULT_W + int'(index))*DATA_WIDTH +: DATA_WIDTH];
    end
  end

endmodule
